// File: rtl/fft_stage_seq.sv
// -----------------------------------------------------------------------------
// fft_stage_seq
//
// Sequencer for a chain of NUM_STAGES registered (1-cycle) butterfly stages in
// the 16-lane parallel FFT datapath. It frames incoming 16-sample blocks into
// FFT frames of BLOCKS_PER_FRAME blocks, drives one capture enable per stage,
// and carries each block's in-frame index (plus sof/eof tags) down the pipeline
// alongside the data. The tags let each stage pick its twiddle/routing set.
//
// Optional feature, enabled by defining FFT_STAGE_SEQ_STATS_EN:
//   frame_cnt / err_cnt saturating statistics counters. When the macro is
//   undefined both ports are tied to 0 and no counter flops exist.
//
// Ports:
//   clk            system clock
//   rstn           asynchronous active-low reset
//   din_valid      input block present this cycle
//   din_sof        input block is first of a frame (qualified by din_valid)
//   stage_en       bit k: stage k captures its input this cycle
//   stage_blk_idx  flat, slice k = in-frame index of the block entering stage k
//   dout_valid     last stage output register holds a valid block
//   dout_sof       output block is index 0 of a frame
//   dout_eof       output block is index BLOCKS_PER_FRAME-1
//   frame_done     dout_valid & dout_eof
//   busy           FSM in RUN or any block still in flight
//   err_sof        1-cycle pulse on a framing error (headless or mid-frame sof)
//   frame_cnt      completed frames (stats feature, else 0)
//   err_cnt        framing errors (stats feature, else 0)
// -----------------------------------------------------------------------------
module fft_stage_seq #(
    parameter int NUM_STAGES       = 3,
    parameter int BLOCKS_PER_FRAME = 32,
    parameter int IDX_W            = 5
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        din_valid,
    input  logic                        din_sof,
    output logic [NUM_STAGES-1:0]       stage_en,
    output logic [NUM_STAGES*IDX_W-1:0] stage_blk_idx,
    output logic                        dout_valid,
    output logic                        dout_sof,
    output logic                        dout_eof,
    output logic                        frame_done,
    output logic                        busy,
    output logic                        err_sof,
    output logic [15:0]                 frame_cnt,
    output logic [7:0]                  err_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCKS_PER_FRAME - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             err_sof_q, err_sof_d;

    // Entry j of the pipeline registers holds the block that left stage j;
    // entry NUM_STAGES-1 is the datapath output register.
    logic [NUM_STAGES-1:0] vld_q, vld_d;
    logic [NUM_STAGES-1:0] sof_q, sof_d;
    logic [NUM_STAGES-1:0] eof_q, eof_d;
    logic [IDX_W-1:0]      idx_q [NUM_STAGES];
    logic [IDX_W-1:0]      idx_d [NUM_STAGES];

    // Stage-0 view of the current input block (combinational).
    logic             acc0;
    logic             sof0;
    logic             eof0;
    logic [IDX_W-1:0] idx0;

    // Framing FSM: decides whether the input block is accepted and which
    // index/tags it carries. A sof always restarts the frame at index 0.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_sof_d = 1'b0;
        acc0      = 1'b0;
        sof0      = 1'b0;
        eof0      = 1'b0;
        idx0      = '0;
        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    if (din_sof) begin
                        acc0    = 1'b1;
                        sof0    = 1'b1;
                        cnt_d   = IDX_W'(1);
                        state_d = RUN;
                    end else begin
                        err_sof_d = 1'b1;   // headless block is dropped
                    end
                end
            end
            RUN: begin
                if (din_valid) begin
                    acc0 = 1'b1;
                    if (din_sof) begin
                        // Abort the current frame; in-flight blocks drain
                        // without an eof.
                        err_sof_d = 1'b1;
                        sof0      = 1'b1;
                        cnt_d     = IDX_W'(1);
                    end else begin
                        idx0 = cnt_q;
                        if (cnt_q == LAST_IDX) begin
                            eof0    = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag pipeline: every entry shifts unconditionally, no backpressure.
    always_comb begin
        vld_d[0] = acc0;
        sof_d[0] = sof0;
        eof_d[0] = eof0;
        idx_d[0] = idx0;
        for (int j = 1; j < NUM_STAGES; j++) begin
            vld_d[j] = vld_q[j-1];
            sof_d[j] = sof_q[j-1];
            eof_d[j] = eof_q[j-1];
            idx_d[j] = idx_q[j-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_sof_q <= 1'b0;
            vld_q     <= '0;
            sof_q     <= '0;
            eof_q     <= '0;
            for (int j = 0; j < NUM_STAGES; j++) begin
                idx_q[j] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_sof_q <= err_sof_d;
            vld_q     <= vld_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            for (int j = 0; j < NUM_STAGES; j++) begin
                idx_q[j] <= idx_d[j];
            end
        end
    end

    // Stage k (k>=1) is fed by pipeline register k-1; stage 0 by the input.
    always_comb begin
        stage_en[0]                = acc0;
        stage_blk_idx[IDX_W-1:0]   = idx0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            stage_en[k]                    = vld_q[k-1];
            stage_blk_idx[k*IDX_W +: IDX_W] = idx_q[k-1];
        end
    end

    assign dout_valid = vld_q[NUM_STAGES-1];
    assign dout_sof   = sof_q[NUM_STAGES-1];
    assign dout_eof   = eof_q[NUM_STAGES-1];
    assign frame_done = vld_q[NUM_STAGES-1] & eof_q[NUM_STAGES-1];
    assign err_sof    = err_sof_q;
    // vld_q covers stage_en[NUM_STAGES-1:1] and dout_valid together.
    assign busy       = (state_q == RUN) | (|vld_q);

`ifdef FFT_STAGE_SEQ_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (frame_done && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (err_sof_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = 16'd0;
    assign err_cnt   = 8'd0;
`endif

endmodule
